// File: rtl/perceptron_trainer_pkg.sv
// Shared types and helpers for the perceptron training sequencer.
package perceptron_trainer_pkg;

  localparam int LANE_WIDTH  = 8;
  localparam int ERROR_WIDTH = 16;

  typedef logic [LANE_WIDTH-1:0]          lane_t;
  typedef logic signed [ERROR_WIDTH-1:0]  error_t;

  // Sequencer states, kept as plain constants for compatibility with older tooling.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ARG  = 3'd1;
  localparam state_t S_RES  = 3'd2;
  localparam state_t S_ERR  = 3'd3;
  localparam state_t S_PROP = 3'd4;
  localparam state_t S_NEXT = 3'd5;
  localparam state_t S_DONE = 3'd6;

  // Training error: unsigned activations zero-extended, difference in 16-bit two's complement.
  function automatic error_t calc_error(input lane_t target, input lane_t result);
    return $signed({8'h00, target}) - $signed({8'h00, result});
  endfunction

endpackage

// File: rtl/perceptron_trainer_sample_store.sv
// Labelled-sample register file: one synchronous write port, one asynchronous read port.
module perceptron_trainer_sample_store
  import perceptron_trainer_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Sample storage is pure data and is never reset; validity is tracked by the sequencer's count.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/perceptron_trainer.sv
// Training sequencer for one perceptron: buffers labelled samples, then replays them in
// epochs (argument -> result -> error -> propagate) until an epoch has no mistakes or the
// epoch limit is reached.
module perceptron_trainer
  import perceptron_trainer_pkg::*;
#(
  parameter int N          = 2,
  parameter int DEPTH      = 8,
  parameter int MAX_EPOCHS = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              start,
  input  logic                              sample_valid,
  input  logic [N-1:0][7:0]                 sample_data,
  input  logic [7:0]                        sample_target,
  output logic                              sample_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              converged,
  output logic [$clog2(MAX_EPOCHS+1)-1:0]   epoch,
  output logic [$clog2(DEPTH+1)-1:0]        mistakes,
  output logic                              train,
  output logic                              argument_valid,
  output logic [N-1:0][7:0]                 argument_data,
  input  logic                              argument_ready,
  input  logic                              result_valid,
  input  logic [7:0]                        result_data,
  output logic                              result_ready,
  output logic                              error_valid,
  output logic [15:0]                       error_data,
  input  logic                              error_ready,
  input  logic                              propagate_valid,
  input  logic [N-1:0][15:0]                propagate_data,
  output logic                              propagate_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = $clog2(MAX_EPOCHS + 1);
  localparam int MW = $clog2(DEPTH + 1);

  typedef struct packed {
    lane_t [N-1:0] x;
    lane_t         target;
  } sample_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  error_t        err_q;
  error_t        res_err;
  sample_t       wr_sample;
  sample_t       rd_sample;
  logic          sample_fire;
  logic          prop_unused;

  // Propagated weight deltas are consumed only for flow control.
  assign prop_unused = ^propagate_data;

  assign sample_ready = (state == S_IDLE) && !start && !clear && (count < CW'(DEPTH));
  assign sample_fire  = sample_valid && sample_ready;
  assign wr_sample    = {sample_data, sample_target};

  perceptron_trainer_sample_store #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (DEPTH),
    .AW    (IW)
  ) u_store (
    .clock   (clock),
    .wr_en   (sample_fire),
    .wr_addr (count[IW-1:0]),
    .wr_data (wr_sample),
    .rd_addr (idx),
    .rd_data (rd_sample)
  );

  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign train           = state inside {S_ARG, S_RES, S_ERR, S_PROP, S_NEXT};
  assign argument_valid  = (state == S_ARG);
  assign argument_data   = rd_sample.x;
  assign result_ready    = (state == S_RES);
  assign error_valid     = (state == S_ERR);
  assign error_data      = err_q;
  assign propagate_ready = (state == S_PROP);
  assign res_err         = calc_error(rd_sample.target, result_data);

  // Error register holds the subtractor output stable for the whole error handshake.
  always_ff @(posedge clock) begin
    if (state == S_RES && result_valid) err_q <= res_err;
  end

  // Sequencer: sample loading in IDLE, then per-sample channel walk and epoch bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      count     <= '0;
      idx       <= '0;
      epoch     <= '0;
      mistakes  <= '0;
      converged <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            count <= '0;
          end else if (start && count != '0) begin
            state     <= S_ARG;
            idx       <= '0;
            epoch     <= '0;
            mistakes  <= '0;
            converged <= 1'b0;
          end else if (sample_fire) begin
            count <= count + CW'(1);
          end
        end
        S_ARG: begin
          if (argument_ready) state <= S_RES;
        end
        S_RES: begin
          if (result_valid) begin
            if (res_err != '0) mistakes <= mistakes + MW'(1);
            state <= S_ERR;
          end
        end
        S_ERR: begin
          if (error_ready) state <= S_PROP;
        end
        S_PROP: begin
          if (propagate_valid) state <= S_NEXT;
        end
        S_NEXT: begin
          if (CW'(idx) + CW'(1) < count) begin
            idx   <= idx + IW'(1);
            state <= S_ARG;
          end else if (mistakes == '0) begin
            converged <= 1'b1;
            state     <= S_DONE;
          end else if (epoch == EW'(MAX_EPOCHS - 1)) begin
            state <= S_DONE;
          end else begin
            epoch    <= epoch + EW'(1);
            mistakes <= '0;
            idx      <= '0;
            state    <= S_ARG;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: a behavioural perceptron stub answers the four channels,
// a scoreboard queue pairs every argument with exactly one expected error.
module tb_perceptron_trainer;

  localparam int N          = 2;
  localparam int DEPTH      = 4;
  localparam int MAX_EPOCHS = 16;

  logic                 clock = 1'b0;
  logic                 reset, clear, start, sample_valid;
  logic [N-1:0][7:0]    sample_data;
  logic [7:0]           sample_target;
  logic                 sample_ready, busy, done, converged, train;
  logic [4:0]           epoch;
  logic [2:0]           mistakes;
  logic                 argument_valid, argument_ready;
  logic [N-1:0][7:0]    argument_data;
  logic                 result_valid, result_ready;
  logic [7:0]           result_data;
  logic                 error_valid, error_ready;
  logic [15:0]          error_data;
  logic                 propagate_valid, propagate_ready;
  logic [N-1:0][15:0]   propagate_data;

  perceptron_trainer #(.N(N), .DEPTH(DEPTH), .MAX_EPOCHS(MAX_EPOCHS)) dut (
    .clock(clock), .reset(reset), .clear(clear), .start(start),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_target(sample_target),
    .sample_ready(sample_ready), .busy(busy), .done(done), .converged(converged),
    .epoch(epoch), .mistakes(mistakes), .train(train),
    .argument_valid(argument_valid), .argument_data(argument_data), .argument_ready(argument_ready),
    .result_valid(result_valid), .result_data(result_data), .result_ready(result_ready),
    .error_valid(error_valid), .error_data(error_data), .error_ready(error_ready),
    .propagate_valid(propagate_valid), .propagate_data(propagate_data),
    .propagate_ready(propagate_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  x0, x1, target, r;
    logic [15:0] exp_err;
  } vec_t;

  vec_t        tab [4];
  logic [7:0]  sx0 [DEPTH+1];
  logic [7:0]  sx1 [DEPTH+1];
  logic [7:0]  st  [DEPTH+1];
  int          nsamp;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  int          mode, stall_en, hold_err, arg_cnt, exp_mist;
  logic        have_res, have_prop, prev_arg_wait, prev_err_wait;
  logic [15:0] prev_arg_data, prev_err_data;
  logic [7:0]  pend_r, and_r, rr;
  logic [15:0] ee;
  int          si, ep;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Perceptron stub plus protocol monitor; drives at the falling edge, decides handshakes 1 ns later.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        argument_ready = 1'b0; result_valid = 1'b0; error_ready = 1'b0; propagate_valid = 1'b0;
        have_res = 1'b0; have_prop = 1'b0; prev_arg_wait = 1'b0; prev_err_wait = 1'b0;
        arg_cnt = 0; exp_q.delete();
      end else begin
        argument_ready  = stall_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
        result_valid    = stall_en != 0 ? 1'($urandom_range(0, 1)) : have_res;
        result_data     = have_res ? pend_r : 8'hEE;
        error_ready     = hold_err != 0 ? 1'b0 : (stall_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
        propagate_valid = have_prop && (stall_en != 0 ? 1'($urandom_range(0, 1)) : 1'b1);
        propagate_data  = {16'hDEAD, 16'hBEEF};
        #1;
        check("one_valid", {31'b0, argument_valid & error_valid}, 0);
        if (argument_valid || error_valid || result_ready || propagate_ready) check("train_hi", train, 1);
        if (!busy) check("train_lo", train, 0);
        if (prev_arg_wait && argument_valid) check("arg_stable", argument_data, prev_arg_data);
        if (prev_err_wait && error_valid) check("err_stable", error_data, prev_err_data);
        prev_arg_wait = argument_valid && !argument_ready;
        prev_arg_data = argument_data;
        prev_err_wait = error_valid && !error_ready;
        prev_err_data = error_data;
        if (argument_valid && argument_ready) begin
          si = (nsamp > 0) ? arg_cnt % nsamp : 0;
          ep = (nsamp > 0) ? arg_cnt / nsamp : 0;
          check("arg_data", argument_data, {sx1[si], sx0[si]});
          and_r = (sx0[si] == 8'hFF && sx1[si] == 8'hFF) ? 8'hFF : 8'h00;
          case (mode)
            0:       rr = and_r;
            1:       rr = (ep == 0) ? ~and_r : and_r;
            2:       rr = ~and_r;
            default: rr = tab[si].r;
          endcase
          ee = (mode == 3) ? tab[si].exp_err : ({8'h00, st[si]} - {8'h00, rr});
          pend_r = rr;
          have_res = 1'b1;
          exp_q.push_back(ee);
          if (si == 0) exp_mist = 0;
          if (ee != 16'h0000) exp_mist++;
          arg_cnt++;
        end
        if (result_valid && result_ready) begin
          check("res_expected", {31'b0, have_res}, 1);
          have_res = 1'b0;
          have_prop = 1'b1;
        end
        if (error_valid && error_ready) begin
          if (exp_q.size() == 0) check("err_unpaired", 1, 0);
          else check("error_data", error_data, exp_q.pop_front());
          check("mistakes_run", mistakes, exp_mist);
        end
        if (propagate_valid && propagate_ready) have_prop = 1'b0;
      end
    end
  end

  task automatic load_sample(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] t,
                             input logic exp_acc);
    @(negedge clock);
    sample_valid = 1'b1; sample_data = {x1, x0}; sample_target = t;
    #1;
    check("sample_ready", sample_ready, exp_acc);
    if (sample_ready && nsamp <= DEPTH) begin
      sx0[nsamp] = x0; sx1[nsamp] = x1; st[nsamp] = t;
      nsamp++;
    end
    @(posedge clock); #1;
    sample_valid = 1'b0;
  endtask

  task automatic load_and_set();
    load_sample(8'h00, 8'h00, 8'h00, 1'b1);
    load_sample(8'h00, 8'hFF, 8'h00, 1'b1);
    load_sample(8'hFF, 8'h00, 8'h00, 1'b1);
    load_sample(8'hFF, 8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic do_clear();
    @(negedge clock); clear = 1'b1;
    @(posedge clock); #1; clear = 1'b0;
    nsamp = 0;
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
  endtask

  task automatic run_training(input string tag, input int exp_epoch, input logic exp_conv,
                              input int exp_mist_final);
    bit seen;
    arg_cnt = 0;
    pulse_start();
    @(negedge clock); #2;
    check({tag, "_busy"}, busy, 1);
    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clock); #2;
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, {31'b0, seen}, 1);
    if (seen) begin
      check({tag, "_converged"}, converged, exp_conv);
      check({tag, "_epoch"}, epoch, exp_epoch);
      check({tag, "_mistakes"}, mistakes, exp_mist_final);
      check({tag, "_queue_empty"}, exp_q.size(), 0);
      check({tag, "_arg_count"}, arg_cnt, (exp_epoch + 1) * nsamp);
    end
    @(negedge clock); #2;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  // Main sequence.
  initial begin
    bit seen;
    reset = 1'b0; clear = 1'b0; start = 1'b0; sample_valid = 1'b0;
    sample_data = '0; sample_target = '0;
    argument_ready = 1'b0; result_valid = 1'b0; result_data = '0;
    error_ready = 1'b0; propagate_valid = 1'b0; propagate_data = '0;
    mode = 0; stall_en = 0; hold_err = 0; arg_cnt = 0; exp_mist = 0; nsamp = 0;
    have_res = 1'b0; have_prop = 1'b0; prev_arg_wait = 1'b0; prev_err_wait = 1'b0;

    tab[0] = '{x0: 8'h01, x1: 8'h02, target: 8'h00, r: 8'hFF, exp_err: 16'hFF01};
    tab[1] = '{x0: 8'h03, x1: 8'h04, target: 8'hFF, r: 8'h00, exp_err: 16'h00FF};
    tab[2] = '{x0: 8'h05, x1: 8'h06, target: 8'h5A, r: 8'h5A, exp_err: 16'h0000};
    tab[3] = '{x0: 8'h07, x1: 8'h08, target: 8'h10, r: 8'h20, exp_err: 16'hFFF0};

    repeat (3) @(negedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_epoch", epoch, 0);
    check("rst_mistakes", mistakes, 0);
    check("rst_converged", converged, 0);
    check("rst_valids", {28'b0, argument_valid, error_valid, result_ready, propagate_ready}, 0);
    check("rst_train", train, 0);
    check("rst_sample_ready", sample_ready, 1);
    @(negedge clock); reset = 1'b1;

    // Start with an empty buffer is ignored.
    pulse_start();
    @(negedge clock); #2;
    check("start_empty", busy, 0);

    // AND set, fifth sample refused, stub already correct.
    load_and_set();
    load_sample(8'h11, 8'h22, 8'h33, 1'b0);
    mode = 0; run_training("and", 0, 1'b1, 0);
    mode = 1; run_training("learn", 1, 1'b1, 0);
    stall_en = 1; run_training("learn_stall", 1, 1'b1, 0); stall_en = 0;
    mode = 2; run_training("wrong", 15, 1'b0, 4);

    // Table-driven error values, including a zero error that must still be sent.
    do_clear();
    for (int i = 0; i < 4; i++) load_sample(tab[i].x0, tab[i].x1, tab[i].target, 1'b1);
    mode = 3; run_training("table", 15, 1'b0, 3);

    // Clear beats a simultaneous sample; status of the last run holds.
    load_sample(8'h01, 8'h01, 8'h01, 1'b0);
    do_clear();
    load_sample(8'h01, 8'h01, 8'h01, 1'b1);
    load_sample(8'h02, 8'h02, 8'h02, 1'b1);
    @(negedge clock); clear = 1'b1; sample_valid = 1'b1;
    #1; check("clear_beats_sample", sample_ready, 0);
    @(posedge clock); #1; clear = 1'b0; sample_valid = 1'b0; nsamp = 0;
    pulse_start();
    @(negedge clock); #2;
    check("clear_count_zero", busy, 0);
    check("hold_epoch", epoch, 15);
    check("hold_converged", converged, 0);

    // Reset while waiting in ERR aborts everything, including the buffer.
    load_and_set();
    mode = 0; hold_err = 1; arg_cnt = 0;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clock); #2;
      if (error_valid) seen = 1'b1;
    end
    check("err_reached", {31'b0, seen}, 1);
    reset = 1'b0;
    #1;
    check("abort_valids", {28'b0, argument_valid, error_valid, result_ready, propagate_ready}, 0);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1; hold_err = 0; nsamp = 0;
    pulse_start();
    @(negedge clock); #2;
    check("abort_count_zero", busy, 0);
    load_and_set();
    run_training("restart", 0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
